// File: rtl/dpram_arb_pkg.sv
// Shared types and default sizes for the port-A arbiter
// of the 64x18 dual-port RAM.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_0,
    OWN_1
  } owner_t;

  localparam int ARB_AW       = 6;
  localparam int ARB_DW       = 18;
  localparam int ARB_MAX_HOLD = 4;

endpackage

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// Two-way round-robin pick with an optional forced winner.
// Output grant is one-hot or zero.
module rr_pick2
  import dpram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       force_vld,
  input  logic       force_idx,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      force_vld:     gnt = force_idx ? 2'b10 : 2'b01;
      req0 && req1:  gnt = last ? 2'b01 : 2'b10;
      default:       gnt = {req1, req0};
    endcase
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Port-A arbiter/sequencer for the shared dual-port RAM.
// Optional bounded lock bursts enabled by ARB_LOCK_EN.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_spo
);

  logic       last;
  logic       force_vld;
  logic       force_idx;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       rv0_q;
  logic       rv1_q;

`ifdef ARB_LOCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  owner_t        owner;
  logic [HW-1:0] hold_cnt;
  logic          at_max;
  logic          keep0;
  logic          keep1;

  assign at_max = hold_cnt == HW'(MAX_HOLD);
  assign keep0  = (owner == OWN_0) && req0 && lock0
                  && !(at_max && req1);
  assign keep1  = (owner == OWN_1) && req1 && lock1
                  && !(at_max && req0);

  assign force_vld = keep0 | keep1;
  assign force_idx = keep1;

  // last still names the previous winner here
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN_NONE;
      hold_cnt <= '0;
    end else if (gnt[0]) begin
      owner    <= lock0 ? OWN_0 : OWN_NONE;
      hold_cnt <= (!last) ? (at_max ? hold_cnt : hold_cnt + 1'b1)
                          : HW'(1);
    end else if (gnt[1]) begin
      owner    <= lock1 ? OWN_1 : OWN_NONE;
      hold_cnt <= last ? (at_max ? hold_cnt : hold_cnt + 1'b1)
                       : HW'(1);
    end else begin
      owner    <= OWN_NONE;
      hold_cnt <= '0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = lock0 ^ lock1 ^ (MAX_HOLD > 0);
  assign force_vld   = 1'b0;
  assign force_idx   = 1'b0;
`endif

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .force_vld (force_vld),
    .force_idx (force_idx),
    .gnt       (pick)
  );

  assign gnt  = rst ? 2'b00 : pick;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    ram_we = 1'b0;
    ram_a  = '0;
    ram_di = '0;
    unique case (1'b1)
      gnt[0]: begin
        ram_we = we0;
        ram_a  = addr0;
        ram_di = wdata0;
      end
      gnt[1]: begin
        ram_we = we1;
        ram_a  = addr1;
        ram_di = wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= 1'b1;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      if (gnt[0] || gnt[1])
        last <= gnt[1];
      rv0_q <= gnt[0] & ~we0;
      rv1_q <= gnt[1] & ~we1;
    end
  end

  // a read granted just before reset must not surface during it
  assign rvalid0 = rv0_q & ~rst;
  assign rvalid1 = rv1_q & ~rst;
  assign rdata   = ram_spo;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural
// 64x18 RAM (registered read address) on port A.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, we0 = 0, lock0 = 0;
  logic        req1 = 0, we1 = 0, lock1 = 0;
  logic [5:0]  addr0 = 0, addr1 = 0;
  logic [17:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [17:0] rdata;
  logic        ram_we;
  logic [5:0]  ram_a;
  logic [17:0] ram_di;
  logic [17:0] ram_spo;

  logic [17:0] mem [0:63];
  logic [5:0]  a_q = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    a_q <= ram_a;
  end
  assign ram_spo = mem[a_q];

  dpram_port_arbiter #(
    .AW(6), .DW(18), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0),
    .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1),
    .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_spo(ram_spo)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // advance to the next cycle and leave time to drive inputs
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; lock0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
  endtask

  task automatic chk_gnt(input string tag, input logic [1:0] exp);
    check(tag, {30'd0, gnt1, gnt0}, {30'd0, exp});
  endtask

  task automatic chk_rv(input string tag, input logic [1:0] exp);
    check(tag, {30'd0, rvalid1, rvalid0}, {30'd0, exp});
  endtask

  logic [1:0] pat [0:5];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 18'h10000 | 18'(i);
    mem[63] = 18'h1BEEF;

    // reset with a pending request: nothing may leak out
    idle(); rst = 1; req0 = 1; addr0 = 6'd7;
    tick(); settle();
    chk_gnt("rst_gnt", 2'b00);
    check("rst_we", {31'd0, ram_we}, 0);
    check("rst_a", {26'd0, ram_a}, 0);
    check("rst_di", {14'd0, ram_di}, 0);
    chk_rv("rst_rv", 2'b00);

    // write 5 <- 0x2A5A5 then read it back
    tick(); rst = 0; idle();
    req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 18'h2A5A5;
    settle();
    chk_gnt("wr_gnt", 2'b01);
    check("wr_we", {31'd0, ram_we}, 1);
    check("wr_a", {26'd0, ram_a}, 5);
    check("wr_di", {14'd0, ram_di}, 32'h2A5A5);
    tick(); we0 = 0; wdata0 = 0;
    settle();
    chk_gnt("rd_gnt", 2'b01);
    check("rd_we", {31'd0, ram_we}, 0);
    chk_rv("wr_norv", 2'b00);
    tick(); idle(); settle();
    chk_rv("rd_rv", 2'b01);
    check("rd_data", {14'd0, rdata}, 32'h2A5A5);

    // both reading, unlocked: strict alternation
    tick(); rst = 1; settle();
    tick(); rst = 0;
    req0 = 1; addr0 = 6'd1; req1 = 1; addr1 = 6'd2;
    settle();
    chk_gnt("alt_c1", 2'b01);
    tick(); settle();
    chk_gnt("alt_c2", 2'b10);
    chk_rv("alt_rv1", 2'b01);
    check("alt_d1", {14'd0, rdata}, 32'h10001);
    tick(); settle();
    chk_gnt("alt_c3", 2'b01);
    chk_rv("alt_rv2", 2'b10);
    check("alt_d2", {14'd0, rdata}, 32'h10002);
    tick(); settle();
    chk_gnt("alt_c4", 2'b10);
    chk_rv("alt_rv3", 2'b01);

    // read of 9 granted, then reset hits
    tick(); idle(); rst = 1; settle();
    tick(); rst = 0; req0 = 1; addr0 = 6'd9;
    settle();
    chk_gnt("r9_gnt", 2'b01);
    tick(); idle(); rst = 1; settle();
    chk_rv("r9_rst_rv", 2'b00);
    chk_gnt("r9_rst_gnt", 2'b00);
    check("r9_rst_a", {26'd0, ram_a}, 0);
    tick(); rst = 0; req1 = 1; addr1 = 6'd3;
    settle();
    chk_gnt("post_rst", 2'b10);
    chk_rv("post_rst_rv", 2'b00);

    // idle cycles, then a lone req1 read of 63
    tick(); idle(); settle();
    chk_rv("idle0_rv", 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("idle_we", {31'd0, ram_we}, 0);
      check("idle_a", {26'd0, ram_a}, 0);
      if (i > 0) chk_rv("idle_rv", 2'b00);
    end
    tick(); req1 = 1; addr1 = 6'd63; settle();
    chk_gnt("r63_gnt", 2'b10);
    check("r63_a", {26'd0, ram_a}, 63);
    tick(); idle(); settle();
    chk_rv("r63_rv", 2'b10);
    check("r63_data", {14'd0, rdata}, 32'h1BEEF);

    // constant contention with lock0 held
`ifdef ARB_LOCK_EN
    pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01;
    pat[3] = 2'b01; pat[4] = 2'b10; pat[5] = 2'b01;
`else
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01;
    pat[3] = 2'b10; pat[4] = 2'b01; pat[5] = 2'b10;
`endif
    tick(); rst = 1; settle();
    tick(); rst = 0;
    req0 = 1; lock0 = 1; addr0 = 6'd4;
    req1 = 1; addr1 = 6'd8;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      settle();
      chk_gnt($sformatf("lock_c%0d", i), pat[i]);
    end

    // lock drops after two grants while req1 waits
    tick(); idle(); rst = 1; settle();
    tick(); rst = 0;
    req0 = 1; lock0 = 1; req1 = 1;
    settle();
    chk_gnt("rel_c1", 2'b01);
    tick(); settle();
`ifdef ARB_LOCK_EN
    chk_gnt("rel_c2", 2'b01);
    tick(); lock0 = 0; settle();
    chk_gnt("rel_c3", 2'b10);
    tick(); settle();
    chk_gnt("rel_c4", 2'b01);
`else
    chk_gnt("rel_c2", 2'b10);
    tick(); lock0 = 0; settle();
    chk_gnt("rel_c3", 2'b01);
`endif

    tick(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
